// File: rtl/des_pkg.sv
// DES key schedule constants: PC-1/PC-2 selection tables and rotation amounts.
// Tables hold DES bit numbers (1 = MSB of the respective vector).
package des_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [27:0] rotl(
        input logic [27:0] x,
        input logic [1:0]  n
    );
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(
        input logic [27:0] x,
        input logic [1:0]  n
    );
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 selection: 56-bit {C,D} to 48-bit round subkey.
// cd[55] is DES bit 1, k[47] is PC-2 output bit 1.
import des_pkg::*;

module des_pc2 (
    input  logic [55:0] cd,
    output logic [47:0] k
);

    always_comb begin
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[47-i] = cd[56-PC2[i]];
        end
    end

endmodule

// File: rtl/des_subkey_gen.sv
// Sequential DES key schedule, one subkey per valid/ready handshake.
// Decrypt walks the rotations backwards from C0/D0, so no key storage.
import des_pkg::*;

module des_subkey_gen #(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        last
);

    state_t      state;
    state_t      state_nxt;
    logic [27:0] c;
    logic [27:0] d;
    logic [3:0]  step;
    logic [3:0]  idx;
    logic        dec;
    logic [55:0] pc1_out;
    logic [1:0]  sh;
    logic        hs;
    logic        load;

    always_comb begin
        pc1_out = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_out[55-i] = key[64-PC1[i]];
        end
    end

    assign busy         = (state == RUN);
    assign subkey_valid = busy;
    assign last         = busy && (step == 4'(NROUNDS - 1));
    assign round_idx    = idx;
    assign hs           = subkey_valid && subkey_ready;
    assign load         = (state == IDLE) && start;
    assign sh           = SHIFTS[step + 4'd1];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (hs && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c    <= '0;
            d    <= '0;
            step <= '0;
            idx  <= '0;
            dec  <= 1'b0;
        end else if (load) begin
            dec  <= decrypt;
            step <= '0;
            idx  <= decrypt ? 4'd15 : 4'd0;
            // PC-2(C0,D0) is already K16, so decrypt loads unrotated
            c    <= decrypt ? pc1_out[55:28] : rotl(pc1_out[55:28], SHIFTS[0]);
            d    <= decrypt ? pc1_out[27:0]  : rotl(pc1_out[27:0],  SHIFTS[0]);
        end else if (hs && !last) begin
            step <= step + 4'd1;
            idx  <= dec ? idx - 4'd1 : idx + 4'd1;
            c    <= dec ? rotr(c, sh) : rotl(c, sh);
            d    <= dec ? rotr(d, sh) : rotl(d, sh);
        end
    end

    des_pc2 u_pc2 (
        .cd ({c, d}),
        .k  (subkey)
    );

endmodule

// File: tb/tb_des_subkey_gen.sv
// Directed bench for des_subkey_gen: known-answer subkeys, backpressure,
// start-while-busy, mid-schedule reset and parity-bit independence.
module tb_des_subkey_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        last;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_AP = 64'h123556789ABDDEF0;
    localparam logic [63:0] KEY_B  = 64'h123456789ABCDEF0;
    localparam logic [63:0] KEY_BP = 64'h133557799BBDDFF1;

    logic [47:0] ka [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    logic [47:0] kexp [16];

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int cum_t [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    des_subkey_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .last         (last)
    );

    always #5 clk = ~clk;

    // Kn from cumulative rotation counts applied to C0/D0 positions
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int n);
        logic [55:0] cd0;
        logic [47:0] r;
        int t, p, src;
        t = cum_t[n-1];
        for (int j = 1; j <= 56; j++) cd0[56-j] = k[64-pc1_t[j-1]];
        for (int m = 1; m <= 48; m++) begin
            p = pc2_t[m-1];
            if (p <= 28) src = ((p - 1 + t) % 28) + 1;
            else         src = ((p - 29 + t) % 28) + 29;
            r[48-m] = cd0[56-src];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic begin_sched(input logic [63:0] k, input logic dec);
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic run_rest(input int from, input logic dec);
        int n;
        for (int i = from; i < 16; i++) begin
            n = dec ? 15 - i : i;
            chk($sformatf("subkey%0d", n + 1), subkey, kexp[n]);
            chk($sformatf("idx%0d", n + 1), round_idx, n);
            chk($sformatf("last%0d", n + 1), last, (i == 15));
            chk($sformatf("busy%0d", n + 1), busy, 1'b1);
            tick();
        end
        chk("busy_end", busy, 1'b0);
        chk("valid_end", subkey_valid, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        decrypt      = 1'b0;
        key          = '0;
        subkey_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", subkey_valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_idx", round_idx, 4'd0);
        chk("rst_subkey", subkey, 48'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) kexp[i] = ka[i];
        begin_sched(KEY_A, 1'b0);
        chk("enc_first", subkey, 48'h1B02EFFC7072);
        run_rest(0, 1'b0);
        chk("idx_hold", round_idx, 4'd15);

        begin_sched(KEY_A, 1'b1);
        chk("dec_first", subkey, 48'hCB3D8B0E17F5);
        run_rest(0, 1'b1);

        begin_sched(KEY_A, 1'b0);
        tick();
        tick();
        subkey_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_subkey", subkey, ka[2]);
            chk("bp_idx", round_idx, 4'd2);
            chk("bp_last", last, 1'b0);
            chk("bp_valid", subkey_valid, 1'b1);
            tick();
        end
        subkey_ready = 1'b1;
        tick();
        run_rest(3, 1'b0);

        begin_sched(KEY_A, 1'b0);
        repeat (6) tick();
        chk("sb_idx", round_idx, 4'd6);
        key   = 64'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_rest(7, 1'b0);

        begin_sched(KEY_A, 1'b0);
        repeat (8) tick();
        chk("mr_idx", round_idx, 4'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", busy, 1'b0);
        chk("mr_valid", subkey_valid, 1'b0);
        chk("mr_last", last, 1'b0);
        chk("mr_ridx", round_idx, 4'd0);
        begin_sched(KEY_A, 1'b0);
        chk("mr_k1", subkey, 48'h1B02EFFC7072);
        run_rest(0, 1'b0);

        begin_sched(KEY_AP, 1'b0);
        run_rest(0, 1'b0);

        for (int i = 0; i < 16; i++) kexp[i] = ref_key(KEY_B, i + 1);
        begin_sched(KEY_B, 1'b0);
        run_rest(0, 1'b0);
        begin_sched(KEY_BP, 1'b0);
        run_rest(0, 1'b0);
        begin_sched(KEY_BP, 1'b1);
        run_rest(0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
